// File: rtl/dram_cmd_scheduler.sv
// dram_cmd_scheduler: serialises one L2 request at a time into PRE/ACT/RD/WR DRAM commands with an open-page row table
module dram_cmd_scheduler #(
   parameter int ADDR_WIDTH   = 13,
   parameter int NUM_OF_BANKS = 8,
   parameter int NUM_OF_ROWS  = 128,
   parameter int NUM_OF_COLS  = 8,
   parameter int T_RP         = 2,
   parameter int T_RCD        = 2,
   parameter int T_CL         = 3
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            req_valid,
   output logic                            req_ready,
   input  logic [ADDR_WIDTH-1:0]           req_addr,
   input  logic                            req_write,
   output logic [2:0]                      cmd,
   output logic [$clog2(NUM_OF_BANKS)-1:0] cmd_bank,
   output logic [$clog2(NUM_OF_ROWS)-1:0]  cmd_row,
   output logic [$clog2(NUM_OF_COLS)-1:0]  cmd_col,
   output logic                            resp_valid,
   output logic                            resp_write,
   output logic                            row_hit
);
   localparam int BW   = $clog2(NUM_OF_BANKS);
   localparam int RW   = $clog2(NUM_OF_ROWS);
   localparam int CW   = $clog2(NUM_OF_COLS);
   localparam int TMAX = T_RP > T_RCD ? (T_RP > T_CL ? T_RP : T_CL) : (T_RCD > T_CL ? T_RCD : T_CL);
   localparam int NW   = $clog2(TMAX + 1);
   localparam logic [NW-1:0] RP_L  = NW'(T_RP - 1);
   localparam logic [NW-1:0] RCD_L = NW'(T_RCD - 1);
   localparam logic [NW-1:0] CL_L  = NW'(T_CL - 1);
   localparam logic [2:0] S_IDLE = 3'd0, S_PRE = 3'd1, S_WAIT_RP = 3'd2, S_ACT = 3'd3,
                          S_WAIT_RCD = 3'd4, S_RDWR = 3'd5, S_WAIT_CL = 3'd6, S_RESP = 3'd7;
   localparam logic [2:0] C_NOP = 3'd0, C_ACT = 3'd1, C_RD = 3'd2, C_WR = 3'd3, C_PRE = 3'd4;

   logic [2:0]              state_q, state_d, cmd_q, cmd_d;
   logic [NW-1:0]           cnt_q, cnt_d;
   logic [NUM_OF_BANKS-1:0] open_valid_q;
   logic [RW-1:0]           open_row_q [NUM_OF_BANKS];
   logic [BW-1:0]           bank_q, bank_d, in_bank;
   logic [RW-1:0]           row_q, row_d, in_row;
   logic [CW-1:0]           col_q, col_d;
   logic                    wr_q, wr_d, ready_q, resp_q, resp_wr_q, hit_q;
   logic                    accept, hit, done;

   assign in_bank = req_addr[ADDR_WIDTH-1 -: BW];
   assign in_row  = req_addr[ADDR_WIDTH-BW-1 -: RW];
   assign accept  = req_valid && ready_q;
   assign hit     = open_valid_q[in_bank] && open_row_q[in_bank] == in_row;
   assign done    = cnt_q == NW'(1);
   assign bank_d  = accept ? in_bank : bank_q;
   assign row_d   = accept ? in_row : row_q;
   assign col_d   = accept ? req_addr[CW-1:0] : col_q;
   assign wr_d    = accept ? req_write : wr_q;

   // Next-state and wait-counter logic; counters load one below the delay since the command cycle itself counts
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE:     if (accept) state_d = hit ? S_RDWR : open_valid_q[in_bank] ? S_PRE : S_ACT;
         S_PRE:      begin state_d = T_RP == 1 ? S_ACT : S_WAIT_RP; cnt_d = RP_L; end
         S_WAIT_RP:  begin state_d = done ? S_ACT : S_WAIT_RP; cnt_d = cnt_q - NW'(1); end
         S_ACT:      begin state_d = T_RCD == 1 ? S_RDWR : S_WAIT_RCD; cnt_d = RCD_L; end
         S_WAIT_RCD: begin state_d = done ? S_RDWR : S_WAIT_RCD; cnt_d = cnt_q - NW'(1); end
         S_RDWR:     begin state_d = !wr_q && T_CL > 1 ? S_WAIT_CL : S_RESP; cnt_d = CL_L; end
         S_WAIT_CL:  begin state_d = done ? S_RESP : S_WAIT_CL; cnt_d = cnt_q - NW'(1); end
         default:    state_d = S_IDLE;
      endcase
   end

   // Command encoding from the upcoming state so cmd leaves a register aligned with that state
   always_comb cmd_d = state_d == S_ACT ? C_ACT : state_d == S_PRE ? C_PRE :
                       state_d == S_RDWR ? (wr_d ? C_WR : C_RD) : C_NOP;

   // Control state, latched request fields and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         cmd_q     <= C_NOP;
         bank_q    <= '0;
         row_q     <= '0;
         col_q     <= '0;
         wr_q      <= 1'b0;
         ready_q   <= 1'b0;
         resp_q    <= 1'b0;
         resp_wr_q <= 1'b0;
         hit_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cmd_q     <= cmd_d;
         bank_q    <= bank_d;
         row_q     <= row_d;
         col_q     <= col_d;
         wr_q      <= wr_d;
         ready_q   <= state_d == S_IDLE;
         resp_q    <= state_d == S_RESP;
         resp_wr_q <= state_d == S_RESP && wr_q;
         hit_q     <= accept && hit;
      end
   end

   // Open-row valid bits: set when ACT issues, cleared when PRE issues
   always_ff @(posedge clk or posedge rst) begin
      if (rst) open_valid_q <= '0;
      else if (state_d == S_ACT) open_valid_q[bank_d] <= 1'b1;
      else if (state_d == S_PRE) open_valid_q[bank_d] <= 1'b0;
   end

   // Open-row numbers are only consulted when the matching valid bit is set, so they need no reset
   always_ff @(posedge clk) begin
      if (state_d == S_ACT) open_row_q[bank_d] <= row_d;
   end

   assign req_ready  = ready_q;
   assign cmd        = cmd_q;
   assign cmd_bank   = bank_q;
   assign cmd_row    = row_q;
   assign cmd_col    = col_q;
   assign resp_valid = resp_q;
   assign resp_write = resp_wr_q;
   assign row_hit    = hit_q;
endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// tb_dram_cmd_scheduler: directed scoreboard bench for the DRAM command scheduler
module tb_dram_cmd_scheduler;
   localparam int T_RP = 2, T_RCD = 2, T_CL = 3;

   typedef struct packed {
      int         cyc;
      logic [2:0] cmd;
      logic [2:0] bank;
      logic [6:0] row;
      logic [2:0] col;
      logic       resp;
      logic       rw;
      logic       hit;
   } ev_t;

   logic        clk = 1'b0, rst = 1'b1;
   logic        req_valid = 1'b0, req_write = 1'b0;
   logic [12:0] req_addr = '0;
   logic        req_ready, resp_valid, resp_write, row_hit;
   logic [2:0]  cmd, cmd_bank, cmd_col;
   logic [6:0]  cmd_row;
   int          cyc = 0;
   int          checks = 0, errors = 0;
   ev_t         q[$];
   logic        mv [8];
   logic [6:0]  mr [8];

   dram_cmd_scheduler #(.T_RP(T_RP), .T_RCD(T_RCD), .T_CL(T_CL)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_write(req_write), .cmd(cmd), .cmd_bank(cmd_bank),
      .cmd_row(cmd_row), .cmd_col(cmd_col), .resp_valid(resp_valid),
      .resp_write(resp_write), .row_hit(row_hit)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic ev_t mk(int c, logic [2:0] k, logic [2:0] b, logic [6:0] r, logic [2:0] co,
                              logic rv, logic rw, logic h);
      ev_t e;
      e.cyc = c; e.cmd = k; e.bank = b; e.row = r; e.col = co; e.resp = rv; e.rw = rw; e.hit = h;
      return e;
   endfunction

   // Expected command/response stream for a request accepted at the edge that ends cycle n
   task automatic push_req(input logic [12:0] a, input logic w, input int n);
      logic [2:0] b = a[12:10];
      logic [6:0] r = a[9:3];
      logic [2:0] c = a[2:0];
      int cc;
      if (mv[b] && mr[b] == r) begin
         cc = n + 1;
         q.push_back(mk(cc, w ? 3'd3 : 3'd2, b, 7'd0, c, 1'b0, 1'b0, 1'b1));
      end else if (!mv[b]) begin
         q.push_back(mk(n + 1, 3'd1, b, r, 3'd0, 1'b0, 1'b0, 1'b0));
         cc = n + 1 + T_RCD;
         q.push_back(mk(cc, w ? 3'd3 : 3'd2, b, 7'd0, c, 1'b0, 1'b0, 1'b0));
      end else begin
         q.push_back(mk(n + 1, 3'd4, b, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0));
         q.push_back(mk(n + 1 + T_RP, 3'd1, b, r, 3'd0, 1'b0, 1'b0, 1'b0));
         cc = n + 1 + T_RP + T_RCD;
         q.push_back(mk(cc, w ? 3'd3 : 3'd2, b, 7'd0, c, 1'b0, 1'b0, 1'b0));
      end
      q.push_back(mk(cc + (w ? 1 : T_CL), 3'd0, 3'd0, 7'd0, 3'd0, 1'b1, w, 1'b0));
      mv[b] = 1'b1;
      mr[b] = r;
   endtask

   task automatic tick();
      ev_t o, e;
      @(negedge clk);
      if (cmd != 3'd0 || resp_valid || row_hit) begin
         o.cyc = cyc; o.cmd = cmd; o.resp = resp_valid; o.rw = resp_write; o.hit = row_hit;
         o.bank = cmd != 3'd0 ? cmd_bank : 3'd0;
         o.row = cmd == 3'd1 ? cmd_row : 7'd0;
         o.col = (cmd == 3'd2 || cmd == 3'd3) ? cmd_col : 3'd0;
         e = '0;
         if (q.size() > 0) e = q.pop_front();
         checks++;
         assert (o === e) else begin
            errors++;
            $error("FAIL event: observed %p required %p", o, e);
         end
      end
      if (q.size() > 0) begin
         checks++;
         assert (q[0].cyc >= cyc) else begin
            errors++;
            $error("FAIL missing: event %p not seen by cycle %0d", q[0], cyc);
            void'(q.pop_front());
         end
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!req_ready && n < 100) begin tick(); n++; end
      checks++;
      assert (req_ready === 1'b1) else begin
         errors++;
         $error("FAIL ready_wait: req_ready=%b required 1", req_ready);
      end
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() > 0 && n < 200) begin tick(); n++; end
      checks++;
      assert (q.size() == 0) else begin
         errors++;
         $error("FAIL drain: %0d events outstanding required 0", q.size());
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      checks++;
      assert ({req_ready, cmd, cmd_bank, cmd_row, cmd_col, resp_valid, resp_write, row_hit} === 20'd0) else begin
         errors++;
         $error("FAIL %s: outputs=%h required 0", tag,
                {req_ready, cmd, cmd_bank, cmd_row, cmd_col, resp_valid, resp_write, row_hit});
      end
   endtask

   task automatic do_req(input logic [12:0] a, input logic w);
      wait_ready();
      req_valid = 1'b1; req_addr = a; req_write = w;
      push_req(a, w, cyc);
      tick();
      req_valid = 1'b0; req_addr = ~a; req_write = ~w;
      checks++;
      assert (req_ready === 1'b0) else begin
         errors++;
         $error("FAIL busy_ready: req_ready=%b required 0", req_ready);
      end
      drain();
   endtask

   initial begin
      logic [12:0] ba [3];
      logic        bw [3];
      int          acc, n;
      for (int i = 0; i < 8; i++) begin mv[i] = 1'b0; mr[i] = '0; end
      tick();
      tick();
      check_reset_outputs("reset_state");
      rst = 1'b0;
      tick();
      tick();
      checks++;
      assert (req_ready === 1'b1) else begin
         errors++;
         $error("FAIL ready_after_reset: req_ready=%b required 1", req_ready);
      end
      repeat (3) tick();
      // closed read, hit read, conflict write
      do_req(13'h0008, 1'b0);
      do_req(13'h0009, 1'b0);
      do_req(13'h0010, 1'b1);
      // per-bank independence
      do_req(13'h1C07, 1'b1);
      do_req(13'h0010, 1'b0);
      // reset during WAIT_RCD
      wait_ready();
      req_valid = 1'b1; req_addr = 13'h0400; req_write = 1'b0;
      push_req(13'h0400, 1'b0, cyc);
      tick();
      req_valid = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      check_reset_outputs("mid_reset");
      q.delete();
      for (int i = 0; i < 8; i++) mv[i] = 1'b0;
      tick();
      tick();
      check_reset_outputs("held_reset");
      rst = 1'b0;
      repeat (10) tick();
      do_req(13'h0400, 1'b0);
      // req_valid held high across three requests with junk inputs while busy
      ba[0] = 13'h0018; bw[0] = 1'b1;
      ba[1] = 13'h0401; bw[1] = 1'b0;
      ba[2] = 13'h0020; bw[2] = 1'b0;
      acc = 0;
      n = 0;
      req_valid = 1'b1;
      while (acc < 3 && n < 300) begin
         if (req_ready) begin
            req_addr = ba[acc]; req_write = bw[acc];
            push_req(ba[acc], bw[acc], cyc);
            acc++;
         end else begin
            req_addr = 13'($urandom); req_write = 1'($urandom);
         end
         tick();
         n++;
      end
      req_valid = 1'b0;
      checks++;
      assert (acc == 3) else begin
         errors++;
         $error("FAIL burst_accepts: accepted %0d required 3", acc);
      end
      drain();
      repeat (5) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
